calc_cmd_sequencer: RTL and testbench
=====================================

// Module: calc_cmd_sequencer
// PURPOSE
//  Synthesizable command front-end for the FSM-controlled 4-bit calculator.
//  - Accepts one {A, B, op} command per valid/ready handshake.
//  - Replays the calculator's pin protocol: start pulse, load A, load B, compute.
//  - Captures result/flags when calculator asserts done; returns them on a valid/ready response port.
//  - Sits between a host/UART/switch layer and the calculator core.
// PARAMETERS
//  ENTER_CYCLES    1   cycles enter is held high per load (>=1)
//  SETTLE_CYCLES   1   idle cycles after each enter pulse before next step (>=1)
//  TIMEOUT_CYCLES  16  max cycles in COMPUTE waiting for done (>=2)
//  SKIP_SAME_A     1   1: skip LOAD_A when cmd_a equals last loaded A (A already valid)
// PORTS
//  clk           in   1  clock, rising edge
//  reset_n       in   1  asynchronous active-low reset
//  cmd_valid     in   1  command present
//  cmd_ready     out  1  sequencer can accept command
//  cmd_a         in   4  operand A
//  cmd_b         in   4  operand B
//  cmd_op        in   2  00 ADD, 01 SUB, 10 MUL, 11 DIV
//  start         out  1  calculator start pulse
//  enter         out  1  calculator enter strobe
//  data_in       out  4  calculator operand bus
//  op_code       out  3  000 idle, 001 load A, 011 load B, 101 compute
//  compute_op    out  2  calculator ALU select
//  calc_result   in   8  calculator result
//  calc_done     in   1  calculator done
//  calc_negative in   1  calculator negative flag
//  calc_div0     in   1  calculator div-by-zero flag
//  rsp_valid     out  1  response present
//  rsp_ready     in   1  consumer accepts response
//  rsp_result    out  8  captured result
//  rsp_flags     out  3  {timeout, div0, negative}
// BEHAVIOUR
//  Reset values:
//  - all outputs 0; state INIT.
//  - internal a_valid=0 and last_a=0; reset_n low mid-command aborts it with no response.
//  FSM states and transitions:
//  - INIT: start=1 for exactly one cycle -> GAP_S; GAP_S waits SETTLE_CYCLES -> IDLE.
//  - IDLE: cmd_ready=1, op_code=000. cmd_valid&cmd_ready latches a/b/op (single cycle).
//      -> LOAD_A, or -> LOAD_B when SKIP_SAME_A && a_valid && cmd_a==last_a.
//  - LOAD_A: op_code=001, data_in=A, enter=1 for ENTER_CYCLES.
//      Then GAP_A (enter=0, op_code/data_in held) for SETTLE_CYCLES; last_a<=A, a_valid<=1.
//  - LOAD_B: op_code=011, data_in=B, same enter/gap timing (GAP_B).
//  - COMPUTE: op_code=101, compute_op=op; cycle counter cleared on entry.
//      First cycle calc_done is sampled 1 (earliest the cycle after entry):
//        capture calc_result and {0, calc_div0, calc_negative} -> RESP.
//      Counter reaches TIMEOUT_CYCLES without done: rsp_result=0, flags=100, a_valid<=0 -> RESP.
//  - RESP: op_code=000, rsp_valid=1, data stable until rsp_ready; handshake -> IDLE.
//      rsp_valid and cmd_ready are never both 1.
//  Timing and width rules:
//  - cmd_ready=0 in every state except IDLE.
//  - Back-to-back commands: min latency cmd accept -> rsp_valid =
//      2*(ENTER_CYCLES+SETTLE_CYCLES)+2 cycles (1+SETTLE_CYCLES+... less when A skipped).
//  - compute_op and data_in hold their last values outside their own states.
//  - Outputs are registered (no combinational path cmd_* -> calculator pins).
//  - Counters sized $clog2(max(param)+1).
// STRUCTURE
//  calc_pkg:
//  - op_code localparams (OPC_IDLE/LOAD_A/LOAD_B/COMPUTE).
//  - compute_op encodings.
//  - state encoding for this FSM.
//  One sub-module: calc_strobe_timer.
//  - Loadable down-counter shared by ENTER/SETTLE/TIMEOUT waits; outputs expired.
// TESTING (bench pairs DUT with calculator core or behavioural model)
//  - Reset: start pulses once, 1 cycle, SETTLE_CYCLES after reset_n rises; cmd_ready=1 afterwards.
//  - SUB {5,2,01}: op_code 001/data 5 then 011/data 2, one enter each; rsp_result=3, flags=000.
//  - Repeat A: {6,3,11} then {6,0,11} with SKIP_SAME_A=1.
//      Second cmd shows no op_code 001 phase; flags div0=1.
//  - Timeout: model holds done=0 -> rsp_valid after 16 COMPUTE cycles, flags=100, result 0;
//      next cmd reloads A.
//  - Backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, cmd_ready=0; then accept, IDLE.
//  - reset_n low during LOAD_B: all outputs 0 at once (async); no rsp_valid; INIT replays start.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared encodings for the calculator command sequencer: calculator pin codes, ALU selects
// and the sequencer state type.
package calc_pkg;

    localparam logic [2:0] OPC_IDLE    = 3'b000;
    localparam logic [2:0] OPC_LOAD_A  = 3'b001;
    localparam logic [2:0] OPC_LOAD_B  = 3'b011;
    localparam logic [2:0] OPC_COMPUTE = 3'b101;

    localparam logic [1:0] CALC_ADD = 2'b00;
    localparam logic [1:0] CALC_SUB = 2'b01;
    localparam logic [1:0] CALC_MUL = 2'b10;
    localparam logic [1:0] CALC_DIV = 2'b11;

    typedef enum logic [3:0] {
        StInit,
        StGapS,
        StIdle,
        StLoadA,
        StGapA,
        StLoadB,
        StGapB,
        StCompute,
        StResp
    } seq_state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/calc_strobe_timer.sv
// Loadable down-counter shared by the enter, settle and compute-timeout waits.
// expired is high while the count sits at zero.
module calc_strobe_timer #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign count   = count_q;
    assign expired = (count_q == '0);

endmodule

// File: rtl/calc_cmd_sequencer.sv
// Command front-end for the 4-bit calculator: replays start / load A / load B / compute on the
// calculator pins for each accepted command and returns the captured result on a response port.
module calc_cmd_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned ENTER_CYCLES   = 1,
    parameter int unsigned SETTLE_CYCLES  = 1,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter bit          SKIP_SAME_A    = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [1:0] cmd_op,
    output logic       start,
    output logic       enter,
    output logic [3:0] data_in,
    output logic [2:0] op_code,
    output logic [1:0] compute_op,
    input  logic [7:0] calc_result,
    input  logic       calc_done,
    input  logic       calc_negative,
    input  logic       calc_div0,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic [2:0] rsp_flags
);

    localparam int unsigned CNT_W =
        $clog2(max3(ENTER_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES) + 1);
    localparam logic [CNT_W-1:0] ENTER_LOAD   = CNT_W'(ENTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_e state_q, state_d;
    logic [3:0] a_q, a_d, b_q, b_d, last_a_q, last_a_d;
    logic [1:0] op_q, op_d;
    logic       a_valid_q, a_valid_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_value, tmr_count;
    logic             tmr_expired;
    logic             compute_first;

    logic       start_d, enter_d, cmd_ready_d, rsp_valid_d;
    logic [3:0] data_in_d;
    logic [2:0] op_code_d;
    logic [1:0] compute_op_d;
    logic [7:0] rsp_result_d;
    logic [2:0] rsp_flags_d;

    calc_strobe_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (tmr_load),
        .load_value (tmr_value),
        .count      (tmr_count),
        .expired    (tmr_expired)
    );

    // The calculator can answer no earlier than the cycle after it first sees COMPUTE.
    assign compute_first = (tmr_count == TIMEOUT_LOAD);

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        last_a_d     = last_a_q;
        a_valid_d    = a_valid_q;
        tmr_load     = 1'b0;
        tmr_value    = '0;
        rsp_result_d = rsp_result;
        rsp_flags_d  = rsp_flags;

        case (state_q)
            StInit: begin
                // First cycle raises start, second cycle drops it.
                if (start) begin
                    state_d   = StGapS;
                    tmr_load  = 1'b1;
                    tmr_value = SETTLE_LOAD;
                end
            end
            StGapS: begin
                if (tmr_expired) state_d = StIdle;
            end
            StIdle: begin
                if (cmd_valid && cmd_ready) begin
                    a_d       = cmd_a;
                    b_d       = cmd_b;
                    op_d      = cmd_op;
                    tmr_load  = 1'b1;
                    tmr_value = ENTER_LOAD;
                    if (SKIP_SAME_A && a_valid_q && (cmd_a == last_a_q)) begin
                        state_d = StLoadB;
                    end else begin
                        state_d = StLoadA;
                    end
                end
            end
            StLoadA: begin
                if (tmr_expired) begin
                    state_d   = StGapA;
                    tmr_load  = 1'b1;
                    tmr_value = SETTLE_LOAD;
                end
            end
            StGapA: begin
                if (tmr_expired) begin
                    state_d   = StLoadB;
                    tmr_load  = 1'b1;
                    tmr_value = ENTER_LOAD;
                    last_a_d  = a_q;
                    a_valid_d = 1'b1;
                end
            end
            StLoadB: begin
                if (tmr_expired) begin
                    state_d   = StGapB;
                    tmr_load  = 1'b1;
                    tmr_value = SETTLE_LOAD;
                end
            end
            StGapB: begin
                if (tmr_expired) begin
                    state_d   = StCompute;
                    tmr_load  = 1'b1;
                    tmr_value = TIMEOUT_LOAD;
                end
            end
            StCompute: begin
                if (calc_done && !compute_first) begin
                    state_d      = StResp;
                    rsp_result_d = calc_result;
                    rsp_flags_d  = {1'b0, calc_div0, calc_negative};
                end else if (tmr_expired) begin
                    // The calculator's A register can no longer be trusted.
                    state_d      = StResp;
                    rsp_result_d = '0;
                    rsp_flags_d  = 3'b100;
                    a_valid_d    = 1'b0;
                end
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StInit;
        endcase

        // Pin values are decoded from the next state so the output flops track the state.
        start_d      = (state_d == StInit);
        enter_d      = (state_d == StLoadA) || (state_d == StLoadB);
        cmd_ready_d  = (state_d == StIdle);
        rsp_valid_d  = (state_d == StResp);
        data_in_d    = data_in;
        compute_op_d = compute_op;
        op_code_d    = OPC_IDLE;
        case (state_d)
            StLoadA: begin
                op_code_d = OPC_LOAD_A;
                data_in_d = a_d;
            end
            StGapA:  op_code_d = OPC_LOAD_A;
            StLoadB: begin
                op_code_d = OPC_LOAD_B;
                data_in_d = b_d;
            end
            StGapB:  op_code_d = OPC_LOAD_B;
            StCompute: begin
                op_code_d    = OPC_COMPUTE;
                compute_op_d = op_d;
            end
            default: op_code_d = OPC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StInit;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            last_a_q   <= '0;
            a_valid_q  <= 1'b0;
            start      <= 1'b0;
            enter      <= 1'b0;
            cmd_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            data_in    <= '0;
            op_code    <= '0;
            compute_op <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            last_a_q   <= last_a_d;
            a_valid_q  <= a_valid_d;
            start      <= start_d;
            enter      <= enter_d;
            cmd_ready  <= cmd_ready_d;
            rsp_valid  <= rsp_valid_d;
            data_in    <= data_in_d;
            op_code    <= op_code_d;
            compute_op <= compute_op_d;
            rsp_result <= rsp_result_d;
            rsp_flags  <= rsp_flags_d;
        end
    end

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Bench for calc_cmd_sequencer: a behavioural calculator answers the pin protocol while an
// arithmetic reference predicts each response, its latency and whether A is reloaded.
module tb_calc_cmd_sequencer;
    import calc_pkg::*;

    localparam int ENTER   = 1;
    localparam int SETTLE  = 1;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_valid, cmd_ready;
    logic [3:0] cmd_a, cmd_b;
    logic [1:0] cmd_op;
    logic       start, enter;
    logic [3:0] data_in;
    logic [2:0] op_code;
    logic [1:0] compute_op;
    logic [7:0] calc_result;
    logic       calc_done, calc_negative, calc_div0;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_result;
    logic [2:0] rsp_flags;

    logic       hold_done;
    logic [3:0] m_a, m_b;
    int         n_start = 0, n_enter_a = 0, n_enter_b = 0, n_both = 0;
    int         errors = 0, checks = 0;
    bit         ref_a_valid;
    logic [3:0] ref_last_a;

    always #5 clk = ~clk;

    calc_cmd_sequencer #(
        .ENTER_CYCLES   (ENTER),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .SKIP_SAME_A    (1'b1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_a         (cmd_a),
        .cmd_b         (cmd_b),
        .cmd_op        (cmd_op),
        .start         (start),
        .enter         (enter),
        .data_in       (data_in),
        .op_code       (op_code),
        .compute_op    (compute_op),
        .calc_result   (calc_result),
        .calc_done     (calc_done),
        .calc_negative (calc_negative),
        .calc_div0     (calc_div0),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_flags     (rsp_flags)
    );

    // {div0, negative, result}; SUB reports magnitude plus a negative flag.
    function automatic logic [9:0] calc_ref(input logic [3:0] a, input logic [3:0] b,
                                            input logic [1:0] op);
        logic [7:0] wa, wb;
        wa = {4'h0, a};
        wb = {4'h0, b};
        case (op)
            CALC_ADD: return {2'b00, wa + wb};
            CALC_SUB: return (a >= b) ? {2'b00, wa - wb} : {2'b01, wb - wa};
            CALC_MUL: return {2'b00, wa * wb};
            default:  return (b == 4'h0) ? {2'b10, 8'h00} : {2'b00, wa / wb};
        endcase
    endfunction

    // Calculator core model: answers one cycle after it sees COMPUTE unless hold_done is set.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_a           <= '0;
            m_b           <= '0;
            calc_done     <= 1'b0;
            calc_result   <= '0;
            calc_negative <= 1'b0;
            calc_div0     <= 1'b0;
        end else begin
            if (enter && op_code == OPC_LOAD_A) m_a <= data_in;
            if (enter && op_code == OPC_LOAD_B) m_b <= data_in;
            if (op_code == OPC_COMPUTE && !hold_done) begin
                calc_done <= 1'b1;
                {calc_div0, calc_negative, calc_result} <= calc_ref(m_a, m_b, compute_op);
            end else begin
                calc_done <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (start) n_start <= n_start + 1;
        if (enter && op_code == OPC_LOAD_A) n_enter_a <= n_enter_a + 1;
        if (enter && op_code == OPC_LOAD_B) n_enter_b <= n_enter_b + 1;
        if (rsp_valid && cmd_ready) n_both <= n_both + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] all_outputs();
        return {cmd_ready, start, enter, data_in, op_code, compute_op, rsp_valid, rsp_result,
                rsp_flags};
    endfunction

    task automatic release_reset();
        int s0;
        @(negedge clk);
        s0 = n_start;
        reset_n = 1'b1;
        @(negedge clk);
        check("init_start_high", {start, cmd_ready}, 2'b10);
        @(negedge clk);
        check("init_start_low", {start, cmd_ready}, 2'b00);
        for (int i = 1; i < SETTLE; i++) @(negedge clk);
        @(negedge clk);
        check("init_ready", cmd_ready, 1);
        check("init_start_count", n_start - s0, 1);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
    endtask

    task automatic do_cmd(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                          input bit hold, input int bp);
        bit         skip;
        int         lat, exp_lat, ea0, eb0, bad;
        logic [9:0] r;
        logic [7:0] exp_res;
        logic [2:0] exp_flags;

        skip = ref_a_valid && (a == ref_last_a);
        r = calc_ref(a, b, op);
        exp_res   = hold ? 8'h00 : r[7:0];
        exp_flags = hold ? 3'b100 : {1'b0, r[9], r[8]};
        exp_lat   = (skip ? 0 : ENTER + SETTLE) + ENTER + SETTLE + (hold ? TIMEOUT : 2);

        hold_done = hold;
        wait_ready();
        ea0 = n_enter_a;
        eb0 = n_enter_b;
        cmd_valid = 1'b1;
        cmd_a = a;
        cmd_b = b;
        cmd_op = op;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("ready_drop", cmd_ready, 0);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, exp_lat);
        check("rsp_result", rsp_result, exp_res);
        check("rsp_flags", rsp_flags, exp_flags);
        check("ready_in_resp", cmd_ready, 0);
        check("load_a_pulses", n_enter_a - ea0, skip ? 0 : ENTER);
        check("load_b_pulses", n_enter_b - eb0, ENTER);

        bad = 0;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_result !== exp_res || rsp_flags !== exp_flags ||
                cmd_ready !== 1'b0) bad++;
        end
        if (bp > 0) check("backpressure_stable", bad, 0);

        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        hold_done = 1'b0;
        check("rsp_handshake", {rsp_valid, cmd_ready}, 2'b01);

        if (hold) begin
            ref_a_valid = 1'b0;
        end else begin
            ref_a_valid = 1'b1;
            ref_last_a  = a;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset_n = 1'b1;
        cmd_valid = 1'b0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_op = '0;
        rsp_ready = 1'b0;
        hold_done = 1'b0;
        ref_a_valid = 1'b0;
        ref_last_a = '0;
        #1 reset_n = 1'b0;
        #1 check("reset_outputs", all_outputs(), 0);
        repeat (3) @(negedge clk);
        release_reset();

        do_cmd(4'd5, 4'd2, CALC_SUB, 1'b0, 0);
        do_cmd(4'd6, 4'd3, CALC_DIV, 1'b0, 0);
        do_cmd(4'd6, 4'd0, CALC_DIV, 1'b0, 0);
        do_cmd(4'd9, 4'd1, CALC_ADD, 1'b1, 0);
        do_cmd(4'd9, 4'd4, CALC_ADD, 1'b0, 0);
        do_cmd(4'd9, 4'd7, CALC_MUL, 1'b0, 5);
        do_cmd(4'd2, 4'd9, CALC_SUB, 1'b0, 1);

        for (int i = 0; i < 24; i++) begin
            do_cmd(4'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                   2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                   int'($urandom_range(0, 2)));
        end

        // Abort a command in the middle of its B load.
        wait_ready();
        cmd_valid = 1'b1;
        cmd_a = 4'd11;
        cmd_b = 4'd3;
        cmd_op = CALC_ADD;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!(enter === 1'b1 && op_code === OPC_LOAD_B) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reached_load_b", {enter, op_code}, {1'b1, OPC_LOAD_B});
        #2 reset_n = 1'b0;
        #1 check("async_reset_outputs", all_outputs(), 0);
        ref_a_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("no_rsp_in_reset", rsp_valid, 0);
        release_reset();
        do_cmd(4'd11, 4'd3, CALC_ADD, 1'b0, 0);
        do_cmd(4'd11, 4'd2, CALC_MUL, 1'b0, 0);

        check("rsp_valid_and_cmd_ready", n_both, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
